param_seq_detector: RTL and testbench
=====================================

Name: param_seq_detector

Overview:
Parametrised Mealy serial-pattern detector, the next generation of the lab's fixed 4-bit detector. It detects a runtime-programmable pattern of 1..MAX_LEN bits on a 1-bit stream gated by a valid strobe. Three detection modes are supported: sliding-overlap, sliding-non-overlap and framed (fixed blocks, like the original lab detector). It also keeps a saturating match counter and serves as the reusable detector for later lab FSM/keypad designs.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of the match counter
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in  in  1  serial data bit
in_valid  in  1  in is sampled this cycle
cfg_load  in  1  latch pattern/pat_len/mode this cycle
pattern  in  MAX_LEN  pattern; bit [pat_len-1] is first received, bit [0] last
pat_len  in  LEN_W  pattern length, legal 1..MAX_LEN
mode  in  2  0=overlap, 1=non-overlap, 2=framed, 3=reserved (load rejected)
cnt_clr  in  1  synchronous clear of match_cnt
dec  out  1  Mealy match output, combinational from in/in_valid/state
match_cnt  out  CNT_W  saturating count of asserted dec cycles
cfg_err  out  1  registered; last cfg_load was illegal

Behaviour:
- Reset (async, rst=1): hist=0, fill=0, frame_pos=0, pat_r=0, len_r=1, mode_r=0, match_cnt=0, cfg_err=0. dec is 0 while rst=1.
- Config: on cfg_load, legality is pat_len in 1..MAX_LEN and mode!=3.
  - Legal: latch pattern, pat_len and mode; set cfg_err=0.
  - Illegal: keep the old config; set cfg_err=1.
  - Either case: clear hist, fill and frame_pos. dec=0 and in is ignored in that cycle, even if in_valid=1.
- window = {hist[len_r-2:0], in}. For len_r=1, window = in.
- fill counts valid bits held in hist and saturates at len_r-1.
- Overlap (mode 0): dec = in_valid & (fill==len_r-1) & (window==pat_r[len_r-1:0]). On every valid bit, hist shifts left with in and fill increments (saturating). A match does not disturb history, so 1111 with pattern 11 gives 3 matches.
- Non-overlap (mode 1): dec as in mode 0. On a match cycle, fill clears to 0, so the next match needs len_r fresh bits. 1111 with pattern 11 gives 2 matches.
- Framed (mode 2): frame_pos counts valid bits 0..len_r-1 and wraps to 0 after len_r-1 regardless of match. dec = in_valid & (frame_pos==len_r-1) & (window==pat). Since fill equals frame_pos, a partial frame is never matched.
- in_valid=0: all state holds and dec=0.
- match_cnt increments by 1 on each cycle dec=1 and saturates at 2^CNT_W-1.
  - cnt_clr has priority: if cnt_clr and dec occur in the same cycle, match_cnt becomes 0.
  - cfg_load does not clear match_cnt.
- Latency: dec is asserted in the same cycle as the last pattern bit (Mealy, zero latency). match_cnt updates on the following edge.
- Reset mid-stream: all progress is lost and the config returns to its defaults. After reset, the bench must reload the config.

Decomposition:
- Package param_seq_pkg holds:
  - mode encodings: MODE_OVL=2'd0, MODE_NOVL=2'd1, MODE_FRM=2'd2
  - a function to check pattern-length legality
  - a mask function that returns (1<<len)-1
- Sub-module seq_match_cnt: a saturating counter with priority clear, parameter CNT_W, inputs inc and clr.

Test Plan:
- Reset then cfg_load pattern=8'b0000_0111, len=4, mode=2, stream 0111 0111 1111 0111 -> dec=1 on bits 4, 8 and 16 only; match_cnt=3.
- Mode 0, pattern=2'b11, len=2, stream 1111 -> dec on bits 2, 3, 4 (cnt=3). Same stimulus in mode 1 -> dec on bits 2 and 4 (cnt=2).
- Mode 0, len=3, pattern=101, stream 1,[in_valid=0 for 3 cycles],0,1 -> dec=1 only on the final valid bit; dec=0 during the gaps.
- cfg_load with pat_len=0, then separately with mode=3 -> cfg_err=1 and the old config still detects. A legal load then gives cfg_err=0. in_valid=1 in a load cycle is ignored.
- CNT_W=2, repeated matches -> match_cnt goes 1, 2, 3 and sticks at 3. cnt_clr together with dec -> 0.
- Assert rst mid-pattern (after 3 of 4 bits) -> dec=0 and match_cnt=0 immediately. After reload, the partial pattern does not complete a match.

Source files
------------

// File: rtl/param_seq_pkg.sv
// param_seq_pkg: shared mode encodings and length helpers for the serial pattern detector
package param_seq_pkg;
  localparam logic [1:0] MODE_OVL  = 2'd0;
  localparam logic [1:0] MODE_NOVL = 2'd1;
  localparam logic [1:0] MODE_FRM  = 2'd2;
  function automatic logic len_ok(input int len, input int max_len);
    return len >= 1 && len <= max_len;
  endfunction
  function automatic logic [31:0] len_mask(input int len);
    return len >= 32 ? '1 : (32'd1 << len) - 32'd1;
  endfunction
endpackage

// File: rtl/seq_match_cnt.sv
// seq_match_cnt: saturating up-counter where clear wins over increment
module seq_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/param_seq_detector.sv
// param_seq_detector: Mealy detector for a programmable 1..MAX_LEN bit pattern
// with overlap, non-overlap and framed modes plus a saturating match counter.
module param_seq_detector
  import param_seq_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [1:0]         mode,
  input  logic               cnt_clr,
  output logic               dec,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, lmask, raw;
  logic [LEN_W-1:0]   pos_q, pos_d, len_q, len_d, last;
  logic [1:0]         mode_q, mode_d;
  logic               err_q, err_d, legal, take, hit, full;
  assign lmask = MAX_LEN'(len_mask(int'(len_q)));
  // pos tracks the fill count in sliding modes and the frame position in framed mode
  always_comb begin
    last   = len_q - LEN_W'(1);
    raw    = {hist_q, in};
    take   = in_valid & ~cfg_load;
    full   = pos_q == last;
    hit    = take & full & ((raw & lmask) == (pat_q & lmask));
    legal  = len_ok(int'(pat_len), MAX_LEN) && mode != 2'd3;
    hist_d = cfg_load ? '0 : take ? raw[MAX_LEN-2:0] : hist_q;
    pos_d  = cfg_load ? '0 :
             !take ? pos_q :
             (mode_q == MODE_FRM) ? (full ? '0 : pos_q + LEN_W'(1)) :
             (mode_q == MODE_NOVL && hit) ? '0 :
             full ? pos_q : pos_q + LEN_W'(1);
    pat_d  = (cfg_load && legal) ? pattern : pat_q;
    len_d  = (cfg_load && legal) ? pat_len : len_q;
    mode_d = (cfg_load && legal) ? mode : mode_q;
    err_d  = cfg_load ? ~legal : err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist_q <= '0;
      pos_q  <= '0;
      pat_q  <= '0;
      len_q  <= LEN_W'(1);
      mode_q <= MODE_OVL;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pos_q  <= pos_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      err_q  <= err_d;
    end
  // the reset defaults would otherwise match a 0 bit, so dec is forced low during reset
  assign dec     = hit & ~rst;
  assign cfg_err = err_q;
  seq_match_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );
endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: directed and random checks against a bit-queue reference model
module tb_param_seq_detector;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CMAX    = (1 << CNT_W) - 1;
  logic clk = 0, rst = 1, in = 0, in_valid = 0, cfg_load = 0, cnt_clr = 0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic [1:0]         mode = '0;
  logic               dec, cfg_err;
  logic [CNT_W-1:0]   match_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [MAX_LEN-1:0] m_pat;
  int m_len, m_mode, m_cnt;
  bit m_err;
  bit q[$];
  param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .mode(mode), .cnt_clr(cnt_clr),
    .dec(dec), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pat = '0; m_len = 1; m_mode = 0; m_cnt = 0; m_err = 0; q.delete();
  endtask
  // last m_len received bits (newest = b) compared against pattern, newest at bit 0
  function automatic bit model_dec(input bit b, input bit v, input bit ld);
    if (ld || !v) return 0;
    if (m_mode == 2 ? q.size() != m_len - 1 : q.size() < m_len - 1) return 0;
    for (int k = 0; k < m_len; k++)
      if ((k == 0 ? b : q[q.size() - k]) != m_pat[k]) return 0;
    return 1;
  endfunction
  task automatic drive(input bit b, input bit v, input bit ld, input bit clr);
    bit e, legal;
    in = b; in_valid = v; cfg_load = ld; cnt_clr = clr;
    @(negedge clk);
    e = model_dec(b, v, ld);
    chk("dec", 32'(dec), 32'(e));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    @(posedge clk);
    if (ld) begin
      legal = pat_len >= 1 && pat_len <= MAX_LEN && mode != 3;
      if (legal) begin m_pat = pattern; m_len = int'(pat_len); m_mode = int'(mode); end
      m_err = !legal;
      q.delete();
    end else if (v) begin
      if (m_mode == 1 && e) q.delete();
      else begin
        q.push_back(b);
        if (m_mode == 2 && q.size() == m_len) q.delete();
        if (q.size() > MAX_LEN) void'(q.pop_front());
      end
    end
    if (clr) m_cnt = 0;
    else if (e && m_cnt < CMAX) m_cnt++;
    #1;
  endtask
  task automatic load(input logic [MAX_LEN-1:0] p, input int l, input int m, input bit v = 0, input bit b = 0);
    pattern = p; pat_len = LEN_W'(l); mode = 2'(m);
    drive(b, v, 1, 0);
  endtask
  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(bits[i], 1, 0, 0);
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_dec", 32'(dec), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_err", 32'(cfg_err), 0);
    @(posedge clk); #1 rst = 0;
    load(8'b0000_0111, 4, 2);
    stream(32'b0111_0111_1111_0111, 16);
    chk("frm_cnt", 32'(match_cnt), 3);
    drive(0, 0, 0, 1);
    load(8'b11, 2, 0);
    stream(32'b1111, 4);
    chk("ovl_cnt", 32'(match_cnt), 3);
    drive(0, 0, 0, 1);
    load(8'b11, 2, 1);
    stream(32'b1111, 4);
    chk("novl_cnt", 32'(match_cnt), 2);
    drive(0, 0, 0, 1);
    load(8'b101, 3, 0);
    drive(1, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    chk("gap_cnt", 32'(match_cnt), 1);
    load(8'b11, 0, 0);
    chk("err_len0", 32'(cfg_err), 1);
    stream(32'b101, 3);
    chk("old_cfg_cnt", 32'(match_cnt), 2);
    load(8'b11, 2, 3, 1, 1);
    chk("err_mode3", 32'(cfg_err), 1);
    load(8'b11, 2, 0, 1, 1);
    chk("err_clear", 32'(cfg_err), 0);
    drive(0, 0, 0, 1);
    stream(32'b11111, 5);
    chk("sat_cnt", 32'(match_cnt), 3);
    drive(1, 1, 0, 1);
    chk("clr_prio", 32'(match_cnt), 0);
    load(8'b0111, 4, 2);
    stream(32'b011, 3);
    in = 1; in_valid = 1; rst = 1;
    #1;
    chk("midrst_dec", 32'(dec), 0);
    chk("midrst_cnt", 32'(match_cnt), 0);
    @(posedge clk); #1 rst = 0;
    model_reset();
    load(8'b0111, 4, 2);
    drive(1, 1, 0, 0);
    chk("no_partial", 32'(match_cnt), 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0)
        load(MAX_LEN'($urandom), int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom));
      else
        drive(1'($urandom), $urandom_range(0, 3) != 0, 0, $urandom_range(0, 30) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
